// File: rtl/cla_sub_34bit_pipe.sv
// rtl/cla_sub_34bit_pipe.sv - two-stage pipelined carry-lookahead subtractor (A + ~B + 1)
// Low half resolved in stage 1, high half and borrow in stage 2, valid/ready on both sides.
module cla_sub_34bit_pipe #(
  parameter int WIDTH    = 34,
  parameter int LO_WIDTH = 17
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_min,
  input  logic [WIDTH-1:0] i_sub,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_zero,
  output logic             o_valid,
  input  logic             i_ready
);
  localparam int HI_WIDTH = WIDTH - LO_WIDTH;

  logic                s1_valid_q, s1_valid_d;
  logic [LO_WIDTH-1:0] s1_lo_q, s1_lo_d;
  logic                s1_c_q, s1_c_d;
  logic [HI_WIDTH-1:0] s1_a_hi_q, s1_a_hi_d;
  logic [HI_WIDTH-1:0] s1_nb_hi_q, s1_nb_hi_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH:0]      result_q, result_d;
  logic                zero_q, zero_d;

  logic                s1_en, s2_en;
  logic [LO_WIDTH-1:0] lo_nb, lo_g, lo_p, lo_x;
  logic [LO_WIDTH:0]   lo_c;
  logic [HI_WIDTH-1:0] hi_g, hi_p, hi_x, hi_diff;
  logic [HI_WIDTH:0]   hi_c;

  always_comb begin
    s2_en = ~out_valid_q | i_ready;
    s1_en = ~s1_valid_q | s2_en;
  end

  // Stage 1: low-half generate/propagate and carry into the high half.
  always_comb begin
    lo_nb   = ~i_sub[LO_WIDTH-1:0];
    lo_g    = i_min[LO_WIDTH-1:0] & lo_nb;
    lo_p    = i_min[LO_WIDTH-1:0] | lo_nb;
    lo_x    = i_min[LO_WIDTH-1:0] ^ lo_nb;
    lo_c    = '0;
    lo_c[0] = 1'b1;
    for (int i = 0; i < LO_WIDTH; i++) begin
      lo_c[i+1] = lo_g[i] | (lo_p[i] & lo_c[i]);
    end

    s1_valid_d = s1_valid_q;
    s1_lo_d    = s1_lo_q;
    s1_c_d     = s1_c_q;
    s1_a_hi_d  = s1_a_hi_q;
    s1_nb_hi_d = s1_nb_hi_q;
    if (s1_en) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_lo_d    = lo_x ^ lo_c[LO_WIDTH-1:0];
        s1_c_d     = lo_c[LO_WIDTH];
        s1_a_hi_d  = i_min[WIDTH-1:LO_WIDTH];
        s1_nb_hi_d = ~i_sub[WIDTH-1:LO_WIDTH];
      end
    end
  end

  // Stage 2: high half continues from the registered mid carry; borrow is the inverted carry-out.
  always_comb begin
    hi_g    = s1_a_hi_q & s1_nb_hi_q;
    hi_p    = s1_a_hi_q | s1_nb_hi_q;
    hi_x    = s1_a_hi_q ^ s1_nb_hi_q;
    hi_c    = '0;
    hi_c[0] = s1_c_q;
    for (int i = 0; i < HI_WIDTH; i++) begin
      hi_c[i+1] = hi_g[i] | (hi_p[i] & hi_c[i]);
    end
    hi_diff = hi_x ^ hi_c[HI_WIDTH-1:0];

    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = {~hi_c[HI_WIDTH], hi_diff, s1_lo_q};
        zero_d   = ~|{hi_diff, s1_lo_q};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= '0;
      s1_c_q      <= 1'b0;
      s1_a_hi_q   <= '0;
      s1_nb_hi_q  <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lo_q     <= s1_lo_d;
      s1_c_q      <= s1_c_d;
      s1_a_hi_q   <= s1_a_hi_d;
      s1_nb_hi_q  <= s1_nb_hi_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
    end
  end

  assign o_ready  = s1_en;
  assign o_valid  = out_valid_q;
  assign o_result = result_q;
  assign o_zero   = zero_q;

endmodule

// File: tb/tb_cla_sub_34bit_pipe.sv
// tb/tb_cla_sub_34bit_pipe.sv - scoreboard bench for cla_sub_34bit_pipe
// Expected values come from table constants or unsigned 35-bit arithmetic on the operands.
module tb_cla_sub_34bit_pipe;
  logic        i_clk;
  logic        i_rst;
  logic [33:0] i_min;
  logic [33:0] i_sub;
  logic        i_valid;
  logic        o_ready;
  logic [34:0] o_result;
  logic        o_zero;
  logic        o_valid;
  logic        i_ready;

  typedef struct packed {
    logic [34:0] r;
    logic        z;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   rnd_done;

  cla_sub_34bit_pipe dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_min   (i_min),
    .i_sub   (i_sub),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_result(o_result),
    .o_zero  (o_zero),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [33:0] a, input logic [33:0] b);
    exp_t e;
    e.r = {1'b0, a} - {1'b0, b};
    e.z = (e.r[33:0] == 34'h0);
    return e;
  endfunction

  function automatic logic [33:0] rnd34();
    logic [1:0] hi;
    hi = 2'($urandom_range(0, 3));
    return {hi, $urandom()};
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the operands.
  task automatic send(input logic [33:0] a, input logic [33:0] b, input logic [34:0] er, input logic ez);
    bit   acc;
    exp_t e;
    acc     = 1'b0;
    i_min   = a;
    i_sub   = b;
    i_valid = 1'b1;
    e.r     = er;
    e.z     = ez;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge i_clk);
      #1;
      if (o_ready) begin
        q.push_back(e);
        acc = 1'b1;
      end
      @(posedge i_clk);
      #1;
    end
    if (!acc) chk("send_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_rnd();
    logic [33:0] a, b;
    exp_t        e;
    int          m;
    m = $urandom_range(0, 7);
    a = rnd34();
    b = rnd34();
    if (m == 0) b = a;
    if (m == 1) begin
      a = 34'h2_0000 + 34'($urandom_range(0, 3));
      b = 34'($urandom_range(0, 7));
    end
    e = model(a, b);
    send(a, b, e.r, e.z);
  endtask

  task automatic drain();
    i_valid = 1'b0;
    for (int k = 0; k < 100 && q.size() != 0; k++) begin
      @(posedge i_clk);
      #1;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Monitor: pipeline occupancy equals queue depth, so o_ready and each presented result are predictable.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      chk("o_ready", 64'(o_ready), 64'(!(q.size() >= 2 && !i_ready)));
      if (o_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_o_valid", 64'(o_valid), 64'd0);
        end else begin
          chk("o_result", 64'(o_result), 64'(q[0].r));
          chk("o_zero", 64'(o_zero), 64'(q[0].z));
          if (i_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int c0;
    i_rst    = 1'b1;
    i_min    = '0;
    i_sub    = '0;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    rnd_done = 1'b0;
    repeat (3) @(posedge i_clk);
    #3 i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_result", 64'(o_result), 64'd0);
    chk("rst_o_zero", 64'(o_zero), 64'd0);
    chk("rst_o_ready", 64'(o_ready), 64'd1);
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("idle_rst_o_valid", 64'(o_valid), 64'd0);
    chk("idle_rst_o_result", 64'(o_result), 64'd0);
    chk("idle_rst_o_ready", 64'(o_ready), 64'd1);
    @(posedge i_clk);
    #3 i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    send(34'h5, 34'h3, {1'b0, 34'h2}, 1'b0);
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("latency_early", 64'(o_valid), 64'd0);
    @(negedge i_clk);
    chk("latency_2cyc", 64'(o_valid), 64'd1);
    @(posedge i_clk);
    #1;
    send(34'h2_AAAA_5555, 34'h2_AAAA_5555, 35'h0, 1'b1);
    send(34'h0, 34'h1, {1'b1, 34'h3_FFFF_FFFF}, 1'b0);
    send(34'h1, 34'h3_FFFF_FFFF, {1'b1, 34'h2}, 1'b0);
    send(34'h0_0002_0000, 34'h1, {1'b0, 34'h0_0001_FFFF}, 1'b0);
    send(34'h3_FFFF_FFFF, 34'h0, {1'b0, 34'h3_FFFF_FFFF}, 1'b0);
    drain();

    i_ready = 1'b0;
    fork
      begin
        send(34'h5, 34'h1, {1'b0, 34'h4}, 1'b0);
        send(34'h9, 34'h2, {1'b0, 34'h7}, 1'b0);
        send(34'h0, 34'h1, {1'b1, 34'h3_FFFF_FFFF}, 1'b0);
        send(34'h7, 34'h7, 35'h0, 1'b1);
        i_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("bp_full_o_ready", 64'(o_ready), 64'd0);
        chk("bp_full_o_valid", 64'(o_valid), 64'd1);
        repeat (2) @(posedge i_clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();

    c0 = cyc;
    for (int k = 0; k < 8; k++) send_rnd();
    chk("throughput_8ops_cycles", 64'(cyc - c0), 64'd8);
    drain();

    send(34'h9, 34'h1, {1'b0, 34'h8}, 1'b0);
    send(34'h3, 34'h1, {1'b0, 34'h2}, 1'b0);
    i_valid = 1'b0;
    #1 i_rst = 1'b1;
    q.delete();
    #1;
    chk("midop_rst_o_valid", 64'(o_valid), 64'd0);
    chk("midop_rst_o_result", 64'(o_result), 64'd0);
    @(posedge i_clk);
    #3 i_rst = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      chk("post_rst_no_stale", 64'(o_valid), 64'd0);
    end
    @(posedge i_clk);
    #1;
    send(34'h6, 34'h4, {1'b0, 34'h2}, 1'b0);
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("post_rst_latency_early", 64'(o_valid), 64'd0);
    @(negedge i_clk);
    chk("post_rst_latency_2cyc", 64'(o_valid), 64'd1);
    @(posedge i_clk);
    #1;
    drain();

    fork
      begin
        for (int k = 0; k < 300; k++) begin
          send_rnd();
          if ($urandom_range(0, 3) == 0) begin
            i_valid = 1'b0;
            repeat ($urandom_range(1, 2)) begin
              @(posedge i_clk);
              #1;
            end
          end
        end
        i_valid  = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge i_clk);
          #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
        i_ready = 1'b1;
      end
    join
    drain();
    repeat (3) @(posedge i_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
